// File: rtl/alu_pkg.sv
// Shared encodings for the ID->EX ALU control pipe: ALU codes, ALUOp classes, opcodes, funct7 groups.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  // funct3 map shared by R-type (funct7=0000000) and I-type arithmetic
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Combinational decode of (ALUOp, op, funct3, funct7) into ALU control, mul/div flag and legality.
module alu_func_decode
  import alu_pkg::*;
#(
  parameter int SUPPORT_M = 1
) (
  input  logic [1:0] alu_op,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl,
  output logic       is_md,
  output logic [2:0] md_op,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    is_md    = 1'b0;
    md_op    = 3'b000;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_MEM: alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3)
          3'b100, 3'b101: alu_ctrl = ALU_SLT;
          3'b110, 3'b111: alu_ctrl = ALU_SLTU;
          default:        alu_ctrl = ALU_SUB;
        endcase
      end
      ALUOP_ARITH: begin
        if (op == OPC_RTYPE) begin
          if (funct7 == F7_BASE) begin
            alu_ctrl = base_op(funct3);
          end else if (funct7 == F7_ALT) begin
            if (funct3 == 3'b000)      alu_ctrl = ALU_SUB;
            else if (funct3 == 3'b101) alu_ctrl = ALU_SRA;
            else                       illegal  = 1'b1;
          end else if (funct7 == F7_MULDIV) begin
            if (SUPPORT_M != 0) begin
              is_md = 1'b1;
              md_op = funct3;
            end else begin
              illegal = 1'b1;
            end
          end else begin
            illegal = 1'b1;
          end
        end else if (op == OPC_ITYPE) begin
          // funct7 only carries meaning for the shift-immediate forms
          alu_ctrl = base_op(funct3);
          if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
          if (funct3 == 3'b101) begin
            if (funct7 == F7_ALT)       alu_ctrl = ALU_SRA;
            else if (funct7 != F7_BASE) illegal  = 1'b1;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_ctrl = ALU_ADD;
      is_md    = 1'b0;
      md_op    = 3'b000;
    end
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decode with valid/ready handshake and mul/div occupancy modelling.
// M ops hold the stage for LAT cycles; flush kills held and in-flight work.
module alu_ctrl_pipe
  import alu_pkg::*;
#(
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 32,
  parameter int SUPPORT_M = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] ALUOp,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_ctrl,
  output logic       is_md,
  output logic [2:0] md_op,
  output logic       illegal,
  output logic       busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [3:0]    dec_ctrl;
  logic          dec_md, dec_ill, accept, md_long;
  logic [2:0]    dec_mop;

  alu_func_decode #(.SUPPORT_M(SUPPORT_M)) u_dec (
    .alu_op   (ALUOp),
    .op       (op),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (dec_ctrl),
    .is_md    (dec_md),
    .md_op    (dec_mop),
    .illegal  (dec_ill)
  );

  assign accept  = in_valid && in_ready;
  // a one-cycle M op completes like any other op and never occupies the stage
  assign md_long = dec_md && (funct3[2] ? (DIV_LAT > 1) : (MUL_LAT > 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (accept && md_long) state_nxt = ST_MD_BUSY;
        ST_MD_BUSY: if (count <= CW'(1))   state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == ST_MD_BUSY);
    in_ready = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
  end

  // count holds remaining busy cycles; completion fires on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      count     <= '0;
      alu_ctrl  <= ALU_ADD;
      is_md     <= 1'b0;
      md_op     <= 3'b000;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      count     <= '0;
    end else if (state == ST_MD_BUSY) begin
      if (count <= CW'(1)) begin
        out_valid <= 1'b1;
        count     <= '0;
      end else begin
        count <= count - CW'(1);
      end
    end else if (accept) begin
      alu_ctrl  <= dec_ctrl;
      is_md     <= dec_md;
      md_op     <= dec_mop;
      illegal   <= dec_ill;
      out_valid <= !md_long;
      count     <= md_long ? (funct3[2] ? DIV_LOAD : MUL_LOAD) : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Randomized plus directed bench for alu_ctrl_pipe against a transaction-level reference model.
module tb_alu_ctrl_pipe;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [1:0] alu_op = 2'b00;
  logic [6:0] op = 7'h00, funct7 = 7'h00;
  logic [2:0] funct3 = 3'b000;
  logic       flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [3:0] alu_ctrl;
  logic       is_md, illegal, busy;
  logic [2:0] md_op;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference state: pending M op with its due cycle, output-valid flag, held data
  bit         m_vld, m_pend;
  int         m_due;
  logic [3:0] m_ctrl;
  bit         m_md, m_ill;
  logic [2:0] m_mop;
  logic [3:0] base_tbl [0:7];

  always #5 clk = ~clk;

  alu_ctrl_pipe #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .SUPPORT_M(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(alu_op), .op(op), .funct3(funct3), .funct7(funct7), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .is_md(is_md), .md_op(md_op), .illegal(illegal), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic ref_decode(input logic [1:0] a, input logic [6:0] o, input logic [2:0] f3,
                            input logic [6:0] f7, output logic [3:0] c, output bit md,
                            output logic [2:0] mop, output bit ill);
    c = 4'd0; md = 1'b0; mop = 3'd0; ill = 1'b0;
    if (a == 2'd0)      c = 4'd0;
    else if (a == 2'd1) c = f3[2] ? (f3[1] ? 4'd6 : 4'd5) : 4'd1;
    else if (a == 2'd3) ill = 1'b1;
    else if (o == 7'h33) begin
      if (f7 == 7'h00)                   c = base_tbl[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) c = 4'd1;
      else if (f7 == 7'h20 && f3 == 3'd5) c = 4'd9;
      else if (f7 == 7'h01) begin md = 1'b1; mop = f3; end
      else ill = 1'b1;
    end else if (o == 7'h13) begin
      c = base_tbl[f3];
      if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
      if (f3 == 3'd5 && f7 == 7'h20) c = 4'd9;
      else if (f3 == 3'd5 && f7 != 7'h00) ill = 1'b1;
    end else ill = 1'b1;
    if (ill) begin c = 4'd0; md = 1'b0; mop = 3'd0; end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 32'(out_valid), 32'(m_vld));
    check_eq("busy",      32'(busy),      32'(m_pend));
    check_eq("alu_ctrl",  32'(alu_ctrl),  32'(m_ctrl));
    check_eq("is_md",     32'(is_md),     32'(m_md));
    check_eq("md_op",     32'(md_op),     32'(m_mop));
    check_eq("illegal",   32'(illegal),   32'(m_ill));
  endtask

  // one clock cycle: drive at the falling edge, check, then advance the model past the rising edge
  task automatic step(input bit iv, input logic [1:0] a, input logic [6:0] o, input logic [2:0] f3,
                      input logic [6:0] f7, input bit ordy, input bit fl);
    bit nv, np, exp_rdy, acc;
    int lat;
    in_valid = iv; alu_op = a; op = o; funct3 = f3; funct7 = f7; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !m_pend && (!m_vld || ordy) && !fl;
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_outputs();
    acc = iv && exp_rdy;
    nv = m_vld; np = m_pend;
    if (fl) begin
      nv = 1'b0; np = 1'b0;
    end else begin
      if (m_pend && cyc + 1 == m_due) begin nv = 1'b1; np = 1'b0; end
      else if (m_vld && ordy) nv = 1'b0;
      if (acc) begin
        ref_decode(a, o, f3, f7, m_ctrl, m_md, m_mop, m_ill);
        lat = m_md ? (f3[2] ? DIV_LAT : MUL_LAT) : 1;
        if (lat == 1) nv = 1'b1;
        else begin nv = 1'b0; np = 1'b1; m_due = cyc + lat; end
      end
    end
    @(posedge clk);
    m_vld = nv; m_pend = np; cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 7'h00, 3'd0, 7'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; flush = 1'b0;
    m_vld = 1'b0; m_pend = 1'b0; m_ctrl = 4'd0; m_md = 1'b0; m_mop = 3'd0; m_ill = 1'b0;
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    base_tbl[0] = 4'd0; base_tbl[1] = 4'd7; base_tbl[2] = 4'd5; base_tbl[3] = 4'd6;
    base_tbl[4] = 4'd4; base_tbl[5] = 4'd8; base_tbl[6] = 4'd3; base_tbl[7] = 4'd2;
    do_reset();

    step(1'b1, 2'd2, 7'h33, 3'd0, 7'h20, 1'b1, 1'b0);   // SUB
    step(1'b1, 2'd2, 7'h13, 3'd5, 7'h20, 1'b1, 1'b0);   // SRAI
    idle(1);
    step(1'b1, 2'd2, 7'h33, 3'd0, 7'h01, 1'b1, 1'b0);   // MUL
    idle(4);
    step(1'b1, 2'd2, 7'h33, 3'd5, 7'h01, 1'b1, 1'b0);   // DIVU, flushed 5 cycles later
    idle(4);
    step(1'b0, 2'd0, 7'h00, 3'd0, 7'h00, 1'b1, 1'b1);
    step(1'b1, 2'd2, 7'h33, 3'd0, 7'h00, 1'b1, 1'b0);   // ADD right after flush
    step(1'b1, 2'd1, 7'h63, 3'd6, 7'h00, 1'b1, 1'b0);   // BLTU
    step(1'b1, 2'd2, 7'h33, 3'd4, 7'h20, 1'b1, 1'b0);   // illegal R-type
    idle(1);
    step(1'b1, 2'd2, 7'h13, 3'd0, 7'h55, 1'b1, 1'b0);   // ADDI, then stalled
    for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 7'h33, 3'd7, 7'h00, 1'b0, 1'b0);
    step(1'b1, 2'd2, 7'h33, 3'd7, 7'h00, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 2'd2, 7'h33, 3'd4, 7'h01, 1'b1, 1'b0);   // DIV, reset mid-busy
    idle(1);
    do_reset();
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      int r, ro, rf;
      logic [1:0] a;
      logic [6:0] o, f7;
      r  = $urandom_range(0, 15);
      a  = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r == 4) ? 2'd3 : 2'd2;
      ro = $urandom_range(0, 19);
      o  = (ro < 9) ? 7'h33 : (ro < 18) ? 7'h13 : 7'($urandom);
      rf = $urandom_range(0, 9);
      f7 = (rf < 5) ? 7'h00 : (rf < 7) ? 7'h20 : (rf < 9) ? 7'h01 : 7'($urandom);
      step($urandom_range(0, 3) != 0, a, o, 3'($urandom), f7,
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
